par_rr_switch: RTL

- Parametrised successor to the fixed 5-port NoC router core: PORTS input channels, each with a DEPTH-entry flit FIFO, switched to PORTS registered output channels.
- Each output has its own round-robin arbiter; routing is source-routed from a destination field in the flit header.
- Parallel valid/busy handshakes on every port.
- Optional windowed flit-activity counter for load monitoring.

---
 rtl/par_rr_switch_if.sv | 13 +
 rtl/par_rr_switch.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/par_rr_switch_if.sv
// Parallel channel bundle for par_rr_switch: PORTS flits with per-channel valid/busy.
// The master drives flits and valids; the slave answers with per-channel busy.
interface par_rr_switch_if #(
  parameter int PORTS  = 5,
  parameter int FLIT_W = 32
);
  logic [PORTS*FLIT_W-1:0] data;
  logic [PORTS-1:0]        valid;
  logic [PORTS-1:0]        busy;

  modport master (output data, output valid, input busy);
  modport slave  (input data, input valid, output busy);
endinterface

// File: rtl/par_rr_switch.sv
// par_rr_switch: PORTS-channel source-routed switch with per-input FIFOs and per-output RR arbiters.
// Optional macro PAR_SWITCH_FLIT_COUNTER_EN adds a windowed accepted-flit counter on flit_counter.
module par_rr_switch #(
  parameter int ROUTERID    = -1,
  parameter int PORTS       = 5,
  parameter int FLIT_W      = 32,
  parameter int DEPTH       = 4,
  parameter int PORT_BITS   = 3,
  parameter int SAMPLE_BITS = 10,
  parameter int CNT_W       = 20
) (
  input  logic             clk,
  input  logic             reset,
  par_rr_switch_if.slave   in_ch,
  par_rr_switch_if.master  out_ch,
  output logic             drop,
  output logic [CNT_W-1:0] flit_counter
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(PORTS);

  if (ROUTERID < -1 || PORTS < 2 || PORTS > 16 || DEPTH < 2 || (1 << AW) != DEPTH ||
      (1 << PORT_BITS) < PORTS || PORT_BITS > FLIT_W || SAMPLE_BITS < 1 || CNT_W < 1) begin : g_param_check
    $error("par_rr_switch: illegal parameter combination");
  end

  logic [FLIT_W-1:0]               mem [PORTS][DEPTH];
  logic [PORTS-1:0][AW-1:0]        wr_ptr;
  logic [PORTS-1:0][AW-1:0]        rd_ptr;
  logic [PORTS-1:0][CW-1:0]        count;
  logic [PORTS-1:0][FLIT_W-1:0]    head;
  logic [PORTS-1:0][PORT_BITS-1:0] dest;
  logic [PORTS-1:0]                nonempty;
  logic [PORTS-1:0]                illegal;
  logic [PORTS-1:0]                full;
  logic [PORTS-1:0]                push;
  logic [PORTS-1:0]                pop;
  logic [PORTS-1:0][PORTS-1:0]     req;
  logic [PORTS-1:0][IW-1:0]        rr_ptr;
  logic [PORTS-1:0][IW-1:0]        win;
  logic [PORTS-1:0]                found;
  logic [PORTS-1:0]                slot_free;
  logic [PORTS-1:0]                grant;
  logic [PORTS-1:0][FLIT_W-1:0]    out_data_p1;
  logic [PORTS-1:0]                out_vld_p1;
  logic                            drop_p1;

  // Input stage: accept, FIFO status and head-of-line decode
  always_comb begin
    full     = '0;
    push     = '0;
    nonempty = '0;
    illegal  = '0;
    head     = '0;
    dest     = '0;
    for (int i = 0; i < PORTS; i++) begin
      full[i]     = (count[i] == CW'(DEPTH));
      push[i]     = in_ch.valid[i] && !full[i];
      nonempty[i] = (count[i] != '0);
      head[i]     = mem[i][rd_ptr[i]];
      dest[i]     = head[i][FLIT_W-1 -: PORT_BITS];
      illegal[i]  = nonempty[i] && (32'(dest[i]) >= 32'(PORTS));
    end
  end

  assign in_ch.busy = full;

  always_comb begin
    req = '0;
    for (int o = 0; o < PORTS; o++) begin
      for (int i = 0; i < PORTS; i++) begin
        req[o][i] = nonempty[i] && !illegal[i] && (32'(dest[i]) == 32'(o));
      end
    end
  end

  // Per-output round-robin: search starts one past the last winner
  always_comb begin
    int idx;
    idx       = 0;
    found     = '0;
    win       = '0;
    slot_free = '0;
    grant     = '0;
    for (int o = 0; o < PORTS; o++) begin
      for (int k = 1; k <= PORTS; k++) begin
        idx = (int'(rr_ptr[o]) + k) % PORTS;
        if (!found[o] && req[o][idx]) begin
          found[o] = 1'b1;
          win[o]   = IW'(idx);
        end
      end
      slot_free[o] = !out_vld_p1[o] || !out_ch.busy[o];
      grant[o]     = slot_free[o] && found[o];
    end
  end

  // An input's head targets exactly one output, so at most one grant can land on it
  always_comb begin
    pop = illegal;
    for (int o = 0; o < PORTS; o++) begin
      if (grant[o]) pop[win[o]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PORTS; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_ch.data[i*FLIT_W +: FLIT_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Output stage: registered flits, arbiter pointers and drop pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_vld_p1  <= '0;
      out_data_p1 <= '0;
      drop_p1     <= 1'b0;
      for (int o = 0; o < PORTS; o++) rr_ptr[o] <= IW'(PORTS - 1);
    end else begin
      drop_p1 <= |illegal;
      for (int o = 0; o < PORTS; o++) begin
        if (slot_free[o]) begin
          out_vld_p1[o] <= found[o];
          if (found[o]) begin
            out_data_p1[o] <= head[win[o]];
            rr_ptr[o]      <= win[o];
          end
        end
      end
    end
  end

  assign out_ch.data  = out_data_p1;
  assign out_ch.valid = out_vld_p1;
  assign drop         = drop_p1;

`ifdef PAR_SWITCH_FLIT_COUNTER_EN
  logic [SAMPLE_BITS-1:0] sampler;
  logic [CNT_W-1:0]       running_count;
  logic [CNT_W-1:0]       flit_counter_q;
  logic [CNT_W-1:0]       accepts;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  always_comb begin
    accepts = '0;
    for (int i = 0; i < PORTS; i++) accepts = accepts + CNT_W'(push[i]);
  end

  // Window closes on the all-ones sample, folding in this cycle's accepts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sampler        <= '0;
      running_count  <= '0;
      flit_counter_q <= '0;
    end else if (&sampler) begin
      flit_counter_q <= sat_add(running_count, accepts);
      running_count  <= '0;
      sampler        <= '0;
    end else begin
      sampler       <= sampler + SAMPLE_BITS'(1);
      running_count <= sat_add(running_count, accepts);
    end
  end

  assign flit_counter = flit_counter_q;
`else
  assign flit_counter = '0;
`endif

endmodule
